// File: rtl/lane_serializer_pkg.sv
// Shared types and defaults for the lane serializer.
package lane_serializer_pkg;

    typedef enum logic {IDLE, SEND} ls_state_t;

    localparam int LS_W_DEF = 8;
    localparam int LS_N_DEF = 4;

endpackage

// File: rtl/lane_select.sv
// N:1 lane multiplexer: picks lane idx_i (W bits) out of a packed frame buffer.
module lane_select #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N*W-1:0] lanes_i,
    input  logic [IW-1:0]  idx_i,
    output logic [W-1:0]   lane_o
);

    always_comb begin
        lane_o = '0;
        for (int k = 0; k < N; k++) begin
            if (idx_i == IW'(k)) lane_o = lanes_i[k*W +: W];
        end
    end

endmodule

// File: rtl/lane_serializer.sv
// Captures an N-lane frame and replays it one lane per beat on a narrow valid/ready port.
// Optional even-parity output enabled by LANE_SERIALIZER_PARITY_EN.
//
// state | meaning
// IDLE  | no frame held, ready for a new frame
// SEND  | replaying buffered frame, lane idx on the output
module lane_serializer
    import lane_serializer_pkg::*;
#(
    parameter int W     = LS_W_DEF,
    parameter int N     = LS_N_DEF,
    parameter int CNT_W = 8,
    localparam int IW   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N*W-1:0]   in_lanes_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W-1:0]     out_data_o,
    output logic [IW-1:0]    out_idx_o,
    output logic             out_last_o,
    output logic [CNT_W-1:0] frame_cnt_o
`ifdef LANE_SERIALIZER_PARITY_EN
   ,output logic             out_par_o
`endif
);

    ls_state_t        state_q, state_d;
    logic [N*W-1:0]   buf_q, buf_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0] frame_cnt_q;
    logic             out_valid_q;
    logic [W-1:0]     out_data_q;
    logic             out_last_q;
    logic             beat, on_last, accept;
    logic [W-1:0]     lane_nxt;

    assign on_last    = (idx_q == IW'(N - 1));
    assign beat       = (state_q == SEND) && out_ready_i;
    assign in_ready_o = (state_q == IDLE) || (beat && on_last);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        buf_d   = buf_q;
        idx_d   = idx_q;
        state_d = state_q;
        if (accept) begin
            buf_d   = in_lanes_i;
            idx_d   = '0;
            state_d = SEND;
        end else if (beat) begin
            if (on_last) state_d = IDLE;
            else         idx_d   = idx_q + 1'b1;
        end
    end

    // Output data is registered from the next buffer/index so it appears the cycle after accept.
    lane_select #(.W(W), .N(N), .IW(IW)) u_lane_select (
        .lanes_i (buf_d),
        .idx_i   (idx_d),
        .lane_o  (lane_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            idx_q       <= idx_d;
            out_valid_q <= (state_d == SEND);
            out_data_q  <= lane_nxt;
            out_last_q  <= (state_d == SEND) && (idx_d == IW'(N - 1));
            if (beat && on_last) frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

`ifdef LANE_SERIALIZER_PARITY_EN
    logic out_par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_par_q <= 1'b0;
        else        out_par_q <= ^lane_nxt;
    end

    assign out_par_o = out_par_q;
`endif

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_idx_o   = idx_q;
    assign out_last_o  = out_last_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule
